mem_load_stage: RTL

Parametrised MEM pipeline stage, placed between EX and WB.
- Accepts loads whose SRAM-like data response (data_ok/rdata) returns a variable number of cycles after the EX-stage request.
- Performs byte, half and word (and, for DATA_W=64, double) selection with sign or zero extension.
- Supports a pipeline flush, and discards a stale load response that arrives after the flush.
- Drives a forwarding bus carrying value plus data-ready status, so decode can bypass or stall.

---
 rtl/mycpu_pkg.sv | 24 ++
 rtl/mem_load_stage_extend.sv | 58 +++++
 rtl/mem_load_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
`default_nettype none
// ============================================================================
// mycpu_pkg : load-op encodings and MEM-stage state encodings
// Rev 1.0
// ============================================================================
package mycpu_pkg;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LW  = 3'b100;
  localparam logic [2:0] LD_LWU = 3'b101;
  localparam logic [2:0] LD_LD  = 3'b110;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_HAVE = 2'd2,
    MS_DROP = 2'd3
  } ms_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_load_stage_extend.sv
`default_nettype none
// ============================================================================
// load_extend : lane select and sign/zero extension of load response data
// Rev 1.0
// ============================================================================
module load_extend
  import mycpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [2:0]        ld_op,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] result
);

  logic [OFF_W-1:0]  off_h;
  logic [OFF_W-1:0]  off_w;
  logic [7:0]        b;
  logic [15:0]       h;
  logic [31:0]       w;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;

  // Alignment is guaranteed upstream, so low offset bits are simply dropped.
  assign off_h = offset & ~OFF_W'(1);
  assign off_w = offset & ~OFF_W'(3);

  assign b = rdata[{offset, 3'b000} +: 8];
  assign h = rdata[{off_h, 3'b000} +: 16];
  assign w = rdata[{off_w, 3'b000} +: 32];

  generate
    if (DATA_W == 64) begin : g_w64
      assign w_sext = {{32{w[31]}}, w};
      assign w_zext = {32'b0, w};
    end else begin : g_w32
      assign w_sext = w;
      assign w_zext = w;
    end
  endgenerate

  always_comb begin
    result = rdata;
    case (ld_op)
      LD_LB:   result = {{(DATA_W-8){b[7]}}, b};
      LD_LBU:  result = {{(DATA_W-8){1'b0}}, b};
      LD_LH:   result = {{(DATA_W-16){h[15]}}, h};
      LD_LHU:  result = {{(DATA_W-16){1'b0}}, h};
      LD_LW:   result = w_sext;
      LD_LWU:  result = w_zext;
      default: result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_load_stage.sv
`default_nettype none
// ============================================================================
// mem_load_stage : MEM pipeline stage with variable-latency load response,
// flush with stale-response drop, and a forwarding bus. Rev 1.0
// ============================================================================
module mem_load_stage
  import mycpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic              es_res_from_mem,
  input  logic [2:0]        es_ld_op,
  input  logic              es_gr_we,
  input  logic [DEST_W-1:0] es_dest,
  input  logic [DATA_W-1:0] es_alu_result,
  input  logic [PC_W-1:0]   es_pc,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic              ms_ws_gr_we,
  output logic [DEST_W-1:0] ms_ws_dest,
  output logic [DATA_W-1:0] ms_ws_result,
  output logic [PC_W-1:0]   ms_ws_pc,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              ms_flush,
  output logic              ms_fwd_we,
  output logic [DEST_W-1:0] ms_fwd_dest,
  output logic [DATA_W-1:0] ms_fwd_data,
  output logic              ms_fwd_data_ok
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  ms_state_t         state_q, state_d;
  logic              ms_valid_q, ms_valid_d;
  logic              res_from_mem_q, res_from_mem_d;
  logic [2:0]        ld_op_q, ld_op_d;
  logic              gr_we_q, gr_we_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              ms_ready_go;
  logic              accept;
  logic              retire;
  logic [DATA_W-1:0] load_src;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] final_result;

  assign ms_ready_go = !res_from_mem_q || (state_q == MS_HAVE) ||
                       ((state_q == MS_WAIT) && data_sram_data_ok);
  assign ms_allowin  = (state_q != MS_DROP) &&
                       (!ms_valid_q || (ms_ready_go && ws_allowin));
  assign accept      = es_to_ms_valid && ms_allowin && !ms_flush;
  assign retire      = ms_valid_q && ms_ready_go && ws_allowin;

  // Live rdata in WAIT gives zero added latency; HAVE replays the captured copy.
  assign load_src = (state_q == MS_HAVE) ? rdata_q : data_sram_rdata;

  load_extend #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_extend (
    .ld_op  (ld_op_q),
    .offset (alu_result_q[OFF_W-1:0]),
    .rdata  (load_src),
    .result (load_data)
  );

  assign final_result = res_from_mem_q ? load_data : alu_result_q;

  always_comb begin
    state_d        = state_q;
    ms_valid_d     = ms_valid_q;
    res_from_mem_d = res_from_mem_q;
    ld_op_d        = ld_op_q;
    gr_we_d        = gr_we_q;
    dest_d         = dest_q;
    alu_result_d   = alu_result_q;
    pc_d           = pc_q;
    rdata_d        = rdata_q;

    if (ms_flush) begin
      ms_valid_d = 1'b0;
      // A response is still owed by a WAIT or DROP load unless it shows up now.
      if ((state_q == MS_WAIT || state_q == MS_DROP) && !data_sram_data_ok)
        state_d = MS_DROP;
      else
        state_d = MS_IDLE;
    end else if (state_q == MS_DROP) begin
      if (data_sram_data_ok)
        state_d = MS_IDLE;
    end else if (accept) begin
      ms_valid_d     = 1'b1;
      res_from_mem_d = es_res_from_mem;
      ld_op_d        = es_ld_op;
      gr_we_d        = es_gr_we;
      dest_d         = es_dest;
      alu_result_d   = es_alu_result;
      pc_d           = es_pc;
      state_d        = es_res_from_mem ? MS_WAIT : MS_IDLE;
    end else if (retire) begin
      ms_valid_d = 1'b0;
      state_d    = MS_IDLE;
    end else if (state_q == MS_WAIT && data_sram_data_ok) begin
      rdata_d = data_sram_rdata;
      state_d = MS_HAVE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= MS_IDLE;
      ms_valid_q     <= 1'b0;
      res_from_mem_q <= 1'b0;
      ld_op_q        <= 3'b000;
      gr_we_q        <= 1'b0;
      dest_q         <= '0;
      alu_result_q   <= '0;
      pc_q           <= '0;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      ms_valid_q     <= ms_valid_d;
      res_from_mem_q <= res_from_mem_d;
      ld_op_q        <= ld_op_d;
      gr_we_q        <= gr_we_d;
      dest_q         <= dest_d;
      alu_result_q   <= alu_result_d;
      pc_q           <= pc_d;
      rdata_q        <= rdata_d;
    end
  end

  assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !ms_flush;
  assign ms_ws_gr_we    = ms_valid_q && gr_we_q;
  assign ms_ws_dest     = dest_q;
  assign ms_ws_result   = final_result;
  assign ms_ws_pc       = pc_q;

  assign ms_fwd_we      = ms_valid_q && gr_we_q;
  assign ms_fwd_dest    = dest_q;
  assign ms_fwd_data    = final_result;
  assign ms_fwd_data_ok = !res_from_mem_q || ms_ready_go;

endmodule
`default_nettype wire
